// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, skid-buffer pointer type and helpers for the FIFO read side
package fifo_pkg;
  localparam int SKID_DEPTH = 3;
  typedef logic [1:0] skid_ptr_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic skid_ptr_t ptr_inc(input skid_ptr_t p);
    return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 3-entry circular skid buffer absorbing the FIFO read latency
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_n,
  input  logic                 push,
  input  logic signed [DW-1:0] din,
  input  logic                 pop,
  output logic [1:0]           occ,
  output logic signed [DW-1:0] dout
);
  logic signed [DW-1:0] mem [SKID_DEPTH];
  skid_ptr_t head, tail;
  logic pop_ok;
  assign pop_ok = pop && (occ != 2'd0);
  assign dout = mem[head];
  always_ff @(posedge i_CLK or negedge i_RST_n)
    if (!i_RST_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail      <= ptr_inc(tail);
      end
      if (pop_ok) head <= ptr_inc(head);
      occ <= occ + 2'(push) - 2'(pop_ok);
    end
  // The issue logic upstream must never let a capture land on a full buffer.
  a_no_overflow: assert property (@(posedge i_CLK) disable iff (!i_RST_n)
    !(push && !pop_ok && occ == 2'd3));
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: underflow-safe FIFO read master feeding a valid/ready stream
// Optional o_LVL (undelivered word count) with FIFO_STREAM_READER_LVL_EN.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter  int DW    = 16,
  parameter  int DEPTH = 8,
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_n,
  input  logic [CW-1:0]        i_CNTR,
  output logic                 o_REN,
  input  logic signed [DW-1:0] i_DO,
  output logic                 o_VALID,
  output logic signed [DW-1:0] o_DATA,
  input  logic                 i_READY
`ifdef FIFO_STREAM_READER_LVL_EN
  ,
  output logic [CW:0]          o_LVL
`endif
);
  logic pend;
  logic [1:0] occ;
  logic pop;
  // Reserve a buffer slot for every read in flight so captures never overflow.
  assign o_REN = i_RST_n && (i_CNTR != '0) && (({1'b0, occ} + {2'b0, pend}) < 3'(SKID_DEPTH));
  assign o_VALID = occ != 2'd0;
  assign pop = o_VALID && i_READY;
  always_ff @(posedge i_CLK or negedge i_RST_n)
    if (!i_RST_n) pend <= 1'b0;
    else pend <= o_REN;
  fifo_rd_skid #(.DW(DW)) u_skid (
    .i_CLK  (i_CLK),
    .i_RST_n(i_RST_n),
    .push   (pend),
    .din    (i_DO),
    .pop    (pop),
    .occ    (occ),
    .dout   (o_DATA)
  );
`ifdef FIFO_STREAM_READER_LVL_EN
  assign o_LVL = {1'b0, i_CNTR} + (CW + 1)'(pend) + (CW + 1)'(occ);
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed self-checking bench with a behavioural FIFO model
module tb_fifo_stream_reader;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW-1:0] cntr = '0;
  logic ren;
  logic signed [DW-1:0] do_r = '0;
  logic valid;
  logic signed [DW-1:0] data;
  logic ready = 1'b0;
  logic wen = 1'b0;
  logic signed [DW-1:0] din = '0;
`ifdef FIFO_STREAM_READER_LVL_EN
  logic [CW:0] lvl;
`endif
  int q[$];
  int checks = 0;
  int errors = 0;
  fifo_stream_reader #(.DW(DW), .DEPTH(DEPTH)) dut (
    .i_CLK  (clk),
    .i_RST_n(rst_n),
    .i_CNTR (cntr),
    .o_REN  (ren),
    .i_DO   (do_r),
    .o_VALID(valid),
    .o_DATA (data),
    .i_READY(ready)
`ifdef FIFO_STREAM_READER_LVL_EN
    ,
    .o_LVL  (lvl)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input integer got, input integer exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // FIFO model: registered count and 1-cycle read data; the bench owns clearing q on reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_r <= '0;
      cntr <= CW'(q.size());
    end else begin
      if (ren) begin
        check("no_underflow", integer'(q.size() != 0), 1);
        if (q.size() != 0) do_r <= DW'(q.pop_front());
      end
      if (wen) q.push_back(int'(din));
      cntr <= CW'(q.size());
    end
  end
  function automatic int word(input int k);
    return k * 331 - 16000;
  endfunction
  initial begin
    int ren_e [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    int val_e [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
    int dat_e [8] = '{0, 0, 10, 11, 12, 13, 14, 0};
    int pre [4] = '{-3, 7, 32767, -32768};
    int ren2 [5] = '{0, 1, 0, 0, 0};
    int val2 [5] = '{1, 1, 1, 1, 0};
    int post [2] = '{900, 901};
    int pulses, wr_cnt, rd_idx, got, prev_data;
    logic prev_stall;
    // reset held with five words already in the FIFO
    for (int i = 0; i < 5; i++) q.push_back(10 + i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ren", ren, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_cntr", cntr, 5);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("t1_ren%0d", k), ren, ren_e[k]);
      check($sformatf("t1_valid%0d", k), valid, val_e[k]);
      if (val_e[k] != 0) check($sformatf("t1_data%0d", k), data, dat_e[k]);
      @(negedge clk);
    end
    // stalled consumer: buffer fills to three, then drains in order
    ready = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(pre[i]);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pulses += int'(ren);
    end
    check("t2_pulses", pulses, 3);
    check("t2_occ", dut.occ, 3);
    check("t2_cntr", cntr, 1);
    check("t2_valid", valid, 1);
    check("t2_hold", data, -3);
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t2_ren%0d", k), ren, ren2[k]);
      check($sformatf("t2_valid%0d", k), valid, val2[k]);
      if (k < 4) check($sformatf("t2_data%0d", k), data, pre[k]);
      @(negedge clk);
    end
    // alternating ready with a continuously fed FIFO
    ready = 1'b0;
    wr_cnt = 0;
    rd_idx = 0;
    prev_stall = 1'b0;
    prev_data = 0;
    for (int c = 0; c < 400 && rd_idx < 100; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("t3_stall_valid", valid, 1);
        check("t3_stall_data", data, prev_data);
      end
      ready = ~ready;
      wen = (wr_cnt < 100) && (q.size() < DEPTH);
      if (wen) begin
        din = DW'(word(wr_cnt));
        wr_cnt++;
      end
      if (valid && ready) begin
        check("t3_sb_data", data, word(rd_idx));
        rd_idx++;
      end
      prev_stall = valid && !ready;
      prev_data = int'(data);
    end
    wen = 1'b0;
    check("t3_sb_count", rd_idx, 100);
    // empty FIFO: nothing issued, nothing presented
    ready = 1'b1;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("t4_ren", ren, 0);
      check("t4_valid", valid, 0);
      @(negedge clk);
    end
    // asynchronous reset with occ=2 and a read in flight
    ready = 1'b0;
    for (int i = 0; i < 6; i++) q.push_back(500 + i);
    repeat (4) @(negedge clk);
    check("t5_occ", dut.occ, 2);
    check("t5_pend", dut.pend, 1);
    #1;
    q.delete();
    rst_n = 1'b0;
    #1;
    check("t5_rst_ren", ren, 0);
    check("t5_rst_valid", valid, 0);
    check("t5_rst_data", data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    q.push_back(post[0]);
    q.push_back(post[1]);
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid && ready) begin
        check("t5_post_data", data, (got < 2) ? post[got] : 0);
        got++;
      end
    end
    check("t5_post_count", got, 2);
`ifdef FIFO_STREAM_READER_LVL_EN
    // level stays constant while words migrate into the buffer
    ready = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(i + 1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("lvl%0d", k), lvl, 4);
      @(negedge clk);
    end
    check("lvl_cntr", cntr, 1);
    check("lvl_occ", dut.occ, 3);
    ready = 1'b1;
    repeat (10) @(negedge clk);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
